// File: rtl/spart_driver.sv
// Bus master for the SPART processor interface: programs the baud divisor after
// reset or a baud-switch change, then echoes each received byte back to the transmitter.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h028A,
    parameter logic [15:0] DIV_9600  = 16'h0145,
    parameter logic [15:0] DIV_19200 = 16'h00A2,
    parameter logic [15:0] DIV_38400 = 16'h0050
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_rx,
    output logic       busy
);

    typedef enum logic [2:0] {
        SYNC,
        INIT_LO,
        INIT_HI,
        IDLE,
        RX_RD,
        TX_WAIT,
        TX_WR
    } state_t;

    state_t      state, state_nxt;
    logic        settle;
    logic [1:0]  cfg_m, cfg_s, cfg_lat;
    logic [15:0] divisor;
    logic        drive;
    logic [7:0]  dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_m <= '0;
            cfg_s <= '0;
        end else begin
            cfg_m <= br_cfg;
            cfg_s <= cfg_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SYNC;
            settle <= 1'b0;
        end else begin
            state  <= state_nxt;
            settle <= (state == SYNC);
        end
    end

    // The first programming takes the value cfg_s assumes on this very edge, so the
    // switches held through reset are written at cycle 2 without a redundant reprogram.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_lat <= '0;
        end else if (state == SYNC && settle) begin
            cfg_lat <= cfg_m;
        end else if (state == IDLE && cfg_s != cfg_lat) begin
            cfg_lat <= cfg_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rx <= '0;
        end else if (state == RX_RD) begin
            last_rx <= databus;
        end
    end

    always_comb begin
        case (cfg_lat)
            2'b00:   divisor = DIV_4800;
            2'b01:   divisor = DIV_9600;
            2'b10:   divisor = DIV_19200;
            default: divisor = DIV_38400;
        endcase
    end

    always_comb begin
        state_nxt = state;
        iocs      = 1'b0;
        iorw      = 1'b1;
        ioaddr    = 2'b00;
        drive     = 1'b0;
        dout      = '0;
        case (state)
            SYNC: begin
                if (settle) state_nxt = INIT_LO;
            end
            INIT_LO: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = 2'b10;
                drive     = 1'b1;
                dout      = divisor[7:0];
                state_nxt = INIT_HI;
            end
            INIT_HI: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = 2'b11;
                drive     = 1'b1;
                dout      = divisor[15:8];
                state_nxt = IDLE;
            end
            IDLE: begin
                if (cfg_s != cfg_lat) state_nxt = INIT_LO;
                else if (rda)         state_nxt = RX_RD;
            end
            RX_RD: begin
                iocs      = 1'b1;
                state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (tbr) state_nxt = TX_WR;
            end
            TX_WR: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                drive     = 1'b1;
                dout      = last_rx;
                state_nxt = IDLE;
            end
            default: state_nxt = SYNC;
        endcase
    end

    assign busy    = (state != IDLE);
    assign databus = drive ? dout : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a SPART model answers reads, and every bus
// cycle is checked against an expected-transaction queue built from the echo/program rules.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] last_rx;
    logic       busy;

    logic [7:0] spart_rx;
    logic       spart_oe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];   // {iorw, ioaddr, data}
    logic [1:0]  cur_cfg;
    logic [15:0] div_ref[4];

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
    } cfg_vec_t;

    typedef struct {
        logic [7:0] b;
        int         dly;
        bit         rearm;
        logic [7:0] b2;
        logic [7:0] exp_last;
    } echo_vec_t;

    spart_driver #(
        .DIV_4800 (16'h028A),
        .DIV_9600 (16'h0145),
        .DIV_19200(16'h00A2),
        .DIV_38400(16'h0050)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .br_cfg (br_cfg),
        .rda    (rda),
        .tbr    (tbr),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .last_rx(last_rx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    assign spart_oe = iocs && iorw && (ioaddr == 2'b00);
    assign databus  = spart_oe ? spart_rx : 8'hzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: every cycle with iocs high must be the next expected transaction
    always @(negedge clk) begin
        if (rst_n === 1'b1 && iocs === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected: got rw=%0b addr=%0h data=%0h expected none at %0t",
                         iorw, ioaddr, databus, $time);
            end else begin
                chk("bus_txn", {21'd0, iorw, ioaddr, databus}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_init(input logic [1:0] c);
        exp_q.push_back({1'b0, 2'b10, div_ref[c][7:0]});
        exp_q.push_back({1'b0, 2'b11, div_ref[c][15:8]});
    endtask

    task automatic push_echo(input logic [7:0] b);
        exp_q.push_back({1'b1, 2'b00, b});
        exp_q.push_back({1'b0, 2'b00, b});
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_read(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(iocs && iorw) && n < 30);
        chk(name, {31'd0, (iocs && iorw)}, 32'd1);
    endtask

    // Checks the cycle-exact programming sequence after rst_n rises at a negedge
    task automatic release_and_check_init(input logic [1:0] c);
        push_init(c);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_c1_sync", {30'd0, busy, iocs}, {30'd0, 2'b10});
        @(negedge clk);
        chk("init_c2_lo", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, div_ref[c][7:0]});
        @(negedge clk);
        chk("init_c3_hi", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b11, div_ref[c][15:8]});
        @(negedge clk);
        chk("init_c4_idle", {29'd0, busy, iocs, iorw}, {29'd0, 3'b001});
    endtask

    task automatic set_cfg(input logic [1:0] c, input string name);
        push_init(c);
        br_cfg  = c;
        cur_cfg = c;
        wait_quiet(name);
    endtask

    task automatic echo(input logic [7:0] b, input int dly, input bit cfg_chg,
                        input logic [1:0] new_cfg, input bit rearm, input logic [7:0] b2);
        spart_rx = b;
        tbr      = (dly == 0);
        push_echo(b);
        if (cfg_chg) push_init(new_cfg);
        if (rearm)   push_echo(b2);
        rda = 1'b1;
        wait_read("echo_read_seen");
        rda = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("tx_wait_bus_idle", {30'd0, iocs, busy}, {30'd0, 2'b01});
            if (i == 0 && rearm) begin
                spart_rx = b2;
                rda      = 1'b1;
            end
            if (i == 0 && cfg_chg) begin
                br_cfg  = new_cfg;
                cur_cfg = new_cfg;
            end
        end
        tbr = 1'b1;
        if (rearm) begin
            wait_read("echo_rearm_read_seen");
            rda = 1'b0;
        end
        wait_quiet("echo");
        chk("echo_last_rx", {24'd0, last_rx}, {24'd0, (rearm ? b2 : b)});
    endtask

    cfg_vec_t  cfg_tab[4];
    echo_vec_t echo_tab[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        div_ref[0] = 16'h028A;
        div_ref[1] = 16'h0145;
        div_ref[2] = 16'h00A2;
        div_ref[3] = 16'h0050;

        cfg_tab[0] = '{cfg: 2'b11, lo: 8'h50, hi: 8'h00};
        cfg_tab[1] = '{cfg: 2'b10, lo: 8'hA2, hi: 8'h00};
        cfg_tab[2] = '{cfg: 2'b01, lo: 8'h45, hi: 8'h01};
        cfg_tab[3] = '{cfg: 2'b00, lo: 8'h8A, hi: 8'h02};

        echo_tab[0] = '{b: 8'h00, dly: 0, rearm: 1'b0, b2: 8'h00, exp_last: 8'h00};
        echo_tab[1] = '{b: 8'hFF, dly: 3, rearm: 1'b0, b2: 8'h00, exp_last: 8'hFF};
        echo_tab[2] = '{b: 8'h81, dly: 2, rearm: 1'b1, b2: 8'h7E, exp_last: 8'h7E};
        echo_tab[3] = '{b: 8'h3C, dly: 1, rearm: 1'b0, b2: 8'h00, exp_last: 8'h3C};

        rst_n    = 1'b0;
        br_cfg   = 2'b01;
        cur_cfg  = 2'b01;
        rda      = 1'b0;
        tbr      = 1'b1;
        spart_rx = 8'h00;

        // Reset state and the first programming sequence
        repeat (3) @(negedge clk);
        chk("reset_outputs", {20'd0, iocs, iorw, ioaddr, last_rx, busy},
            {20'd0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1});
        release_and_check_init(2'b01);
        wait_quiet("init");

        // Echo latency with tbr already high
        spart_rx = 8'h5A;
        tbr      = 1'b1;
        push_echo(8'h5A);
        rda = 1'b1;
        @(negedge clk);
        chk("lat_rx_rd", {28'd0, iocs, iorw, ioaddr}, {28'd0, 4'b1100});
        rda = 1'b0;
        @(negedge clk);
        chk("lat_tx_wait", {22'd0, iocs, busy, last_rx}, {22'd0, 2'b01, 8'h5A});
        @(negedge clk);
        chk("lat_tx_wr", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 4'b1000, 8'h5A});
        @(negedge clk);
        chk("lat_idle", {31'd0, busy}, 32'd0);
        wait_quiet("lat");

        // tbr held low for 10 cycles after the read
        echo(8'h5A, 10, 1'b0, 2'b00, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) begin
            push_init(cfg_tab[i].cfg);
            void'(exp_q.pop_back());
            void'(exp_q.pop_back());
            exp_q.push_back({1'b0, 2'b10, cfg_tab[i].lo});
            exp_q.push_back({1'b0, 2'b11, cfg_tab[i].hi});
            br_cfg  = cfg_tab[i].cfg;
            cur_cfg = cfg_tab[i].cfg;
            wait_quiet("cfg_tab");
        end

        for (int i = 0; i < 4; i++) begin
            echo(echo_tab[i].b, echo_tab[i].dly, 1'b0, 2'b00, echo_tab[i].rearm, echo_tab[i].b2);
            chk("echo_tab_last", {24'd0, last_rx}, {24'd0, echo_tab[i].exp_last});
        end

        // cfg 00->10 during TX_WAIT: echo write first, then reprogramming
        echo(8'hC3, 4, 1'b1, 2'b10, 1'b0, 8'h00);

        // Reset asserted during INIT_HI
        push_init(2'b01);
        br_cfg  = 2'b01;
        cur_cfg = 2'b01;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(iocs && ioaddr == 2'b11) && n < 20);
            chk("reach_init_hi", {30'd0, iocs, ioaddr == 2'b11}, {30'd0, 2'b11});
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, iocs, iorw, ioaddr, last_rx, busy},
            {20'd0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1});
        chk("async_reset_q_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        release_and_check_init(2'b01);
        wait_quiet("post_reset");
        echo(8'hA5, 0, 1'b0, 2'b00, 1'b0, 8'h00);

        // Randomised mix of reprogramming and echoes
        for (int it = 0; it < 30; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                set_cfg(2'((int'(cur_cfg) + 1 + int'($urandom_range(0, 2))) % 4), "rand_cfg");
            end else begin
                logic [7:0] b, b2;
                int         dly;
                int         flag;
                b    = 8'($urandom);
                b2   = 8'($urandom);
                dly  = int'($urandom_range(0, 6));
                flag = (dly > 0) ? int'($urandom_range(0, 2)) : 0;
                echo(b, dly, flag == 1,
                     2'((int'(cur_cfg) + 1 + int'($urandom_range(0, 2))) % 4),
                     flag == 2, b2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
